// File: rtl/fetch_queue_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_if
//   Bundles the signals of the instruction-fetch front end that face the
//   instruction cache, the branch unit and decode.
//
//   master : the fetch unit itself
//            drives icache_req/icache_addr and the decode-side head
//            (instr_valid/instr/instr_pc).
//            Receives icache_rvalid/icache_rdata, the redirect
//            (redir_valid/redir_pc) and instr_ready.
//   slave  : the environment (cache + branch unit + decode), directions
//            mirrored.
// ---------------------------------------------------------------------------
interface fetch_queue_unit_if #(
  parameter int AW = 10,
  parameter int IW = 32
);
  logic          icache_req;
  logic [AW-1:0] icache_addr;
  logic          icache_rvalid;
  logic [IW-1:0] icache_rdata;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  modport master (
    output icache_req, icache_addr, instr_valid, instr, instr_pc,
    input  icache_rvalid, icache_rdata, redir_valid, redir_pc, instr_ready
  );

  modport slave (
    input  icache_req, icache_addr, instr_valid, instr, instr_pc,
    output icache_rvalid, icache_rdata, redir_valid, redir_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end. Owns the fetch PC, issues one-word requests
//   to the instruction cache (at most one in flight) and buffers returned
//   instructions in a DEPTH-entry prefetch queue that decode drains with a
//   valid/ready handshake. A branch redirect flushes the queue, reloads the
//   PC and discards any response still in flight.
//
//   Ports:
//     Clk          clock, all state on the rising edge
//     Rst          synchronous active-high reset
//     start        one-cycle pulse, IDLE -> RUN
//     bus          fetch_queue_unit_if.master
//                    icache_req/icache_addr     request strobe + address
//                    icache_rvalid/icache_rdata response for the request
//                    redir_valid/redir_pc       branch redirect
//                    instr_valid/instr/instr_pc queue head towards decode
//                    instr_ready                decode accepts the head
//     instr_count  number of instructions accepted by decode (wraps)
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int            AW       = 10,
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  fetch_queue_unit_if.master        bus,
  output logic [31:0]               instr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   fetch_pc_reg;
  logic [AW-1:0]   req_addr_reg;     // address of the request in flight
  logic            outstanding_reg;
  logic            drop_reg;         // next response belongs to a stale path
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     instr_count_reg;

  // Small register-file queue, read asynchronously so the head is visible
  // in the same cycle that count_reg says it is valid.
  logic [AW-1:0]   entry_pc    [DEPTH];
  logic [IW-1:0]   entry_instr [DEPTH];

  logic            rsp_accept;
  logic            push;
  logic            pop;
  logic            issue;
  logic [CW-1:0]   occ_next;

  always_comb begin
    // Responses only count while a request is actually in flight; stale
    // strobes (e.g. after a reset mid-fetch) fall through here.
    rsp_accept = bus.icache_rvalid && outstanding_reg;
    push       = rsp_accept && !drop_reg && !bus.redir_valid;
    // A redirect flushes the queue, so a handshake that cycle is void.
    pop        = (count_reg != '0) && bus.instr_ready && !bus.redir_valid;
    occ_next   = count_reg + CW'(push) - CW'(pop);
    // A response arriving this cycle frees the single in-flight slot, which
    // is what allows one fetch per cycle from a 1-cycle cache.
    issue      = !Rst && (state_reg == RUN) && !bus.redir_valid && !drop_reg &&
                 (!outstanding_reg || bus.icache_rvalid) &&
                 (occ_next < CW'(DEPTH));
  end

  assign bus.icache_req  = issue;
  assign bus.icache_addr = issue ? fetch_pc_reg : '0;
  assign bus.instr_valid = (count_reg != '0);
  assign bus.instr       = (count_reg != '0) ? entry_instr[head_reg] : '0;
  assign bus.instr_pc    = (count_reg != '0) ? entry_pc[head_reg]    : '0;
  assign instr_count     = instr_count_reg;

  // Control state, PC, in-flight tracking and queue pointers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= IDLE;
      fetch_pc_reg    <= RESET_PC;
      req_addr_reg    <= '0;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      instr_count_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        state_reg <= RUN;
      end

      if (bus.redir_valid) begin
        fetch_pc_reg <= bus.redir_pc;
      end else if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + AW'(PC_STEP);
      end

      if (issue) begin
        req_addr_reg    <= fetch_pc_reg;
        outstanding_reg <= 1'b1;
      end else if (rsp_accept) begin
        outstanding_reg <= 1'b0;
      end

      // A redirect with a request still pending marks its response for
      // discard; the response itself (redirected or not) clears the mark.
      if (rsp_accept) begin
        drop_reg <= 1'b0;
      end else if (bus.redir_valid && outstanding_reg) begin
        drop_reg <= 1'b1;
      end

      if (bus.redir_valid) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) begin
          tail_reg <= tail_reg + PW'(1);
        end
        if (pop) begin
          head_reg <= head_reg + PW'(1);
        end
        count_reg <= occ_next;
      end

      if (pop) begin
        instr_count_reg <= instr_count_reg + 32'd1;
      end
    end
  end

  // Queue storage: written at the tail on push, no reset needed since
  // count_reg masks stale contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      entry_pc[tail_reg]    <= req_addr_reg;
      entry_instr[tail_reg] <= bus.icache_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
//   Directed scenarios plus a randomized run against a queue-based reference
//   model. A second instance with RESET_PC=0x3FE covers PC wrap-around.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int AW    = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] instr_count;
  logic [31:0] instr_count2;

  int checks = 0;
  int failures = 0;

  fetch_queue_unit_if #(.AW(AW), .IW(IW)) bus ();
  fetch_queue_unit_if #(.AW(AW), .IW(IW)) bus2 ();

  fetch_queue_unit #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(10'h000), .PC_STEP(1)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .bus(bus), .instr_count(instr_count)
  );

  fetch_queue_unit #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(10'h3FE), .PC_STEP(1)
  ) dut_wrap (
    .Clk(Clk), .Rst(Rst), .start(start2), .bus(bus2), .instr_count(instr_count2)
  );

  always #5 Clk = ~Clk;

  // ---------------- instruction cache model for the main instance ----------
  logic          req_q;
  logic [AW-1:0] addr_q;
  bit            pend = 1'b0;
  logic [AW-1:0] pend_addr;
  int            pend_cnt;
  int            lat = 1;
  bit            rand_lat = 1'b0;

  always @(negedge Clk) begin
    req_q  = bus.icache_req;
    addr_q = bus.icache_addr;
  end

  function automatic logic [31:0] cache_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + {22'd0, a};
  endfunction

  task automatic cache_update();
    logic rv_now;
    rv_now = 1'b0;
    if (req_q) begin
      pend      = 1'b1;
      pend_addr = addr_q;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        rv_now = 1'b1;
        pend   = 1'b0;
        bus.icache_rdata = cache_word(pend_addr);
      end
    end
    bus.icache_rvalid = rv_now;
    if (!rv_now) bus.icache_rdata = $urandom;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cache_update();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    bus.instr_ready = 1'b0;
    bus2.redir_valid = 1'b0;
    bus2.redir_pc = '0;
    bus2.instr_ready = 1'b0;
    bus2.icache_rvalid = 1'b0;
    bus2.icache_rdata = '0;
    tick();
    tick();
    Rst = 1'b0;
    pend = 1'b0;
    rand_lat = 1'b0;
    bus.icache_rvalid = 1'b0;
    bus.icache_rdata = '0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      checks++;
      if ({bus.icache_req, bus.icache_addr, bus.instr_valid, bus.instr, bus.instr_pc, instr_count} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got req=%0b addr=%h valid=%0b instr=%h pc=%h cnt=%0d expected all zero",
                 bus.icache_req, bus.icache_addr, bus.instr_valid, bus.instr, bus.instr_pc, instr_count);
      end
      tick();
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic [AW:0]      exp_ra;
      logic [AW+IW:0]   exp_hd;
      logic [31:0]      exp_cnt;
      exp_ra  = (c >= 1) ? {1'b1, AW'(c - 1)} : '0;
      exp_hd  = (c >= 3) ? {1'b1, AW'(c - 3), cache_word(AW'(c - 3))} : '0;
      exp_cnt = (c >= 3) ? 32'(c - 3) : 32'd0;
      @(negedge Clk);
      checks++;
      if ({bus.icache_req, bus.icache_addr} !== exp_ra) begin
        failures++;
        $display("FAIL stream_req c=%0d: got %h expected %h", c, {bus.icache_req, bus.icache_addr}, exp_ra);
      end
      checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== exp_hd) begin
        failures++;
        $display("FAIL stream_head c=%0d: got %h expected %h", c, {bus.instr_valid, bus.instr_pc, bus.instr}, exp_hd);
      end
      checks++;
      if (instr_count !== exp_cnt) begin
        failures++;
        $display("FAIL stream_count c=%0d: got %0d expected %0d", c, instr_count, exp_cnt);
      end
      tick();
      start = 1'b0;
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    int nreq;
    int idx;
    bit seen;
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b0;
    start = 1'b1;
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (bus.icache_req) nreq++;
      if (c >= 3) begin
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, AW'(0), cache_word(AW'(0))}) begin
          failures++;
          $display("FAIL bp_head_hold c=%0d: got valid=%0b pc=%h instr=%h expected valid=1 pc=000 instr=a0000000",
                   c, bus.instr_valid, bus.instr_pc, bus.instr);
        end
      end
      if (c >= 6) begin
        checks++;
        if (bus.icache_req !== 1'b0) begin
          failures++;
          $display("FAIL bp_no_req c=%0d: got req=%0b expected 0", c, bus.icache_req);
        end
      end
      tick();
      start = 1'b0;
    end
    checks++;
    if (nreq != DEPTH) begin
      failures++;
      $display("FAIL bp_req_count: got %0d expected %0d", nreq, DEPTH);
    end
    bus.instr_ready = 1'b1;
    idx = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      @(negedge Clk);
      if (bus.instr_valid) begin
        checks++;
        if ({bus.instr_pc, bus.instr} !== {AW'(idx), cache_word(AW'(idx))}) begin
          failures++;
          $display("FAIL bp_drain idx=%0d: got pc=%h instr=%h expected pc=%h", idx, bus.instr_pc, bus.instr, AW'(idx));
        end
        idx++;
      end
      if (bus.icache_req && !seen) begin
        seen = 1'b1;
        checks++;
        if (bus.icache_addr !== AW'(4)) begin
          failures++;
          $display("FAIL bp_resume_addr: got %h expected 004", bus.icache_addr);
        end
      end
      tick();
    end
    checks++;
    if (idx != 6 || !seen) begin
      failures++;
      $display("FAIL bp_drain_timeout: got drained=%0d resumed=%0b expected drained=6 resumed=1", idx, seen);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_inflight();
    bit found;
    bit got;
    int first;
    do_reset();
    lat = 3;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge Clk);
      if (bus.icache_req && bus.icache_addr == AW'(5)) found = 1'b1;
      tick();
      start = 1'b0;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redir_setup: got no request for addr 005 expected one within 40 cycles");
    end
    bus.redir_valid = 1'b1;
    bus.redir_pc = 10'h100;
    @(negedge Clk);
    checks++;
    if (bus.icache_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req: got req=%0b expected 0", bus.icache_req);
    end
    tick();
    bus.redir_valid = 1'b0;
    first = -1;
    got = 1'b0;
    for (int c = 0; c < 25 && !got; c++) begin
      @(negedge Clk);
      if (c == 0) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL redir_flush: got valid=%0b expected 0", bus.instr_valid);
        end
      end
      if (bus.icache_req && first < 0) begin
        first = c;
        checks++;
        if (bus.icache_addr !== 10'h100) begin
          failures++;
          $display("FAIL redir_target: got %h expected 100", bus.icache_addr);
        end
      end
      if (bus.instr_valid) begin
        got = 1'b1;
        checks++;
        if ({bus.instr_pc, bus.instr} !== {10'h100, cache_word(10'h100)}) begin
          failures++;
          $display("FAIL redir_first_instr: got pc=%h instr=%h expected pc=100 instr=a0000100", bus.instr_pc, bus.instr);
        end
      end
      tick();
    end
    checks++;
    if (first != 2 || !got) begin
      failures++;
      $display("FAIL redir_timing: got first_req_cycle=%0d delivered=%0b expected 2 and 1", first, got);
    end
    $display("test_redirect_inflight done");
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    lat = 1;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      tick();
      start = 1'b0;
    end
    bus.redir_valid = 1'b1;
    bus.redir_pc = 10'h040;
    @(negedge Clk);
    checks++;
    if ({bus.icache_req, bus.instr_valid, bus.instr_pc, instr_count} !== {1'b0, 1'b1, AW'(5), 32'd5}) begin
      failures++;
      $display("FAIL rr_cycle: got req=%0b valid=%0b pc=%h cnt=%0d expected req=0 valid=1 pc=005 cnt=5",
               bus.icache_req, bus.instr_valid, bus.instr_pc, instr_count);
    end
    tick();
    bus.redir_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.instr_valid, instr_count} !== {1'b0, 32'd5}) begin
      failures++;
      $display("FAIL rr_flush: got valid=%0b cnt=%0d expected valid=0 cnt=5", bus.instr_valid, instr_count);
    end
    checks++;
    if ({bus.icache_req, bus.icache_addr} !== {1'b1, 10'h040}) begin
      failures++;
      $display("FAIL rr_target: got req=%0b addr=%h expected req=1 addr=040", bus.icache_req, bus.icache_addr);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_empty: got valid=%0b expected 0", bus.instr_valid);
    end
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 10'h040, cache_word(10'h040)}) begin
      failures++;
      $display("FAIL rr_new_head: got valid=%0b pc=%h instr=%h expected valid=1 pc=040",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    tick();
    $display("test_redirect_rvalid done");
  endtask

  task automatic test_wrap();
    logic          r;
    logic [AW-1:0] a;
    do_reset();
    bus2.instr_ready = 1'b1;
    start2 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic [AW:0]    exp_ra;
      logic [AW+IW:0] exp_hd;
      logic [AW-1:0]  ea;
      ea     = 10'h3FE + AW'(c - 1);
      exp_ra = (c >= 1) ? {1'b1, ea} : '0;
      ea     = 10'h3FE + AW'(c - 3);
      exp_hd = (c >= 3) ? {1'b1, ea, cache_word(ea)} : '0;
      @(negedge Clk);
      r = bus2.icache_req;
      a = bus2.icache_addr;
      checks++;
      if ({r, a} !== exp_ra) begin
        failures++;
        $display("FAIL wrap_addr c=%0d: got %h expected %h", c, {r, a}, exp_ra);
      end
      checks++;
      if ({bus2.instr_valid, bus2.instr_pc, bus2.instr} !== exp_hd) begin
        failures++;
        $display("FAIL wrap_head c=%0d: got %h expected %h", c, {bus2.instr_valid, bus2.instr_pc, bus2.instr}, exp_hd);
      end
      checks++;
      if (instr_count2 !== ((c >= 3) ? 32'(c - 3) : 32'd0)) begin
        failures++;
        $display("FAIL wrap_count c=%0d: got %0d", c, instr_count2);
      end
      @(posedge Clk);
      #1;
      start2 = 1'b0;
      bus2.icache_rvalid = r;
      bus2.icache_rdata = cache_word(a);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_midfetch();
    bit got;
    do_reset();
    lat = 2;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(negedge Clk);
    tick();
    start = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.icache_req, bus.icache_addr} !== {1'b1, 10'h000}) begin
      failures++;
      $display("FAIL rm_first_req: got req=%0b addr=%h expected req=1 addr=000", bus.icache_req, bus.icache_addr);
    end
    tick();
    Rst = 1'b1;
    @(negedge Clk);
    tick();
    Rst = 1'b0;
    // The response to the pre-reset request arrives in the first cycle here.
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      checks++;
      if ({bus.icache_req, bus.icache_addr, bus.instr_valid, bus.instr, bus.instr_pc, instr_count} !== '0) begin
        failures++;
        $display("FAIL rm_idle c=%0d: got req=%0b addr=%h valid=%0b instr=%h pc=%h cnt=%0d expected all zero",
                 c, bus.icache_req, bus.icache_addr, bus.instr_valid, bus.instr, bus.instr_pc, instr_count);
      end
      tick();
    end
    start = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.icache_req !== 1'b0) begin
      failures++;
      $display("FAIL rm_start_cycle: got req=%0b expected 0", bus.icache_req);
    end
    tick();
    start = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.icache_req, bus.icache_addr} !== {1'b1, 10'h000}) begin
      failures++;
      $display("FAIL rm_restart: got req=%0b addr=%h expected req=1 addr=000", bus.icache_req, bus.icache_addr);
    end
    tick();
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge Clk);
      if (bus.instr_valid) begin
        got = 1'b1;
        checks++;
        if ({bus.instr_pc, bus.instr} !== {10'h000, cache_word(10'h000)}) begin
          failures++;
          $display("FAIL rm_head: got pc=%h instr=%h expected pc=000 instr=a0000000", bus.instr_pc, bus.instr);
        end
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rm_timeout: got no instruction expected one within 10 cycles");
    end
    $display("test_reset_midfetch done");
  endtask

  task automatic test_random();
    logic [AW-1:0] q[$];
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] inflight_pc;
    logic [31:0]   exp_cnt;
    bit            run;
    bit            inflight;
    bit            discard;
    do_reset();
    rand_lat = 1'b1;
    start = 1'b1;
    q.delete();
    exp_pc = 10'h000;
    inflight_pc = '0;
    exp_cnt = 32'd0;
    run = 1'b0;
    inflight = 1'b0;
    discard = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bit rv, rdy, rd, pop_m, push_m, exp_req;
      int occ;
      logic [AW:0] exp_ra;
      if (c > 0) begin
        bus.instr_ready = ($urandom_range(0, 9) < 7);
        bus.redir_valid = ($urandom_range(0, 24) == 0);
        bus.redir_pc = AW'($urandom);
      end
      @(negedge Clk);
      rv  = bus.icache_rvalid;
      rdy = bus.instr_ready;
      rd  = bus.redir_valid;
      pop_m   = rdy && (q.size() > 0) && !rd;
      push_m  = rv && inflight && !discard && !rd;
      occ     = q.size() + int'(push_m) - int'(pop_m);
      exp_req = run && !rd && !discard && (!inflight || rv) && (occ < DEPTH);
      exp_ra  = exp_req ? {1'b1, exp_pc} : '0;

      checks++;
      if (bus.instr_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_valid c=%0d: got %0b expected %0b", c, bus.instr_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if ({bus.instr_pc, bus.instr} !== {q[0], cache_word(q[0])}) begin
          failures++;
          $display("FAIL rnd_head c=%0d: got pc=%h instr=%h expected pc=%h", c, bus.instr_pc, bus.instr, q[0]);
        end
      end
      checks++;
      if ({bus.icache_req, bus.icache_addr} !== exp_ra) begin
        failures++;
        $display("FAIL rnd_req c=%0d: got req=%0b addr=%h expected %h", c, bus.icache_req, bus.icache_addr, exp_ra);
      end
      checks++;
      if (instr_count !== exp_cnt) begin
        failures++;
        $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, instr_count, exp_cnt);
      end

      if (pop_m) begin
        $display("accept pc=%h instr=%h count=%0d", q[0], cache_word(q[0]), exp_cnt + 1);
        void'(q.pop_front());
        exp_cnt++;
      end
      if (rd) begin
        q.delete();
        if (inflight && rv) begin
          inflight = 1'b0;
          discard = 1'b0;
        end else if (inflight) begin
          discard = 1'b1;
        end
        exp_pc = bus.redir_pc;
      end else begin
        if (rv && inflight) begin
          if (!discard) q.push_back(inflight_pc);
          inflight = 1'b0;
          discard = 1'b0;
        end
        if (exp_req) begin
          inflight = 1'b1;
          inflight_pc = exp_pc;
          exp_pc = exp_pc + 10'd1;
        end
      end
      if (start) run = 1'b1;
      tick();
      start = 1'b0;
    end
    bus.redir_valid = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.icache_rvalid = 1'b0;
    bus.icache_rdata = '0;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    bus.instr_ready = 1'b0;
    bus2.icache_rvalid = 1'b0;
    bus2.icache_rdata = '0;
    bus2.redir_valid = 1'b0;
    bus2.redir_pc = '0;
    bus2.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
